// File: rtl/instr_issue_encoder.sv
// Encodes op descriptors into 32-bit decoder words and issues one per clock.
// Optional RAW bubble insertion under INSTR_ISSUE_HAZARD_NOP_EN.
module instr_issue_encoder #(
  parameter int DEPTH      = 4,
  parameter int HAZARD_GAP = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [4:0]  in_ra,
  input  logic [4:0]  in_rb,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  output logic [31:0] instr_out,
  output logic        instr_real,
  output logic [15:0] issue_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] NOP_W = 32'h0400_029F;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic        w_push;
  logic        w_pop;
  logic        w_empty;
  logic        w_stall;
  logic [31:0] w_enc;
  logic [31:0] w_head;

  always_comb begin
    w_enc = NOP_W;
    unique case (in_op)
      3'd0: w_enc = NOP_W;
      3'd1: w_enc = {6'b000001, in_ra, in_rb, in_rd, 5'd10, 6'd32};
      3'd2: w_enc = {6'b000001, in_ra, in_rb, in_rd, 5'd10, 6'd34};
      3'd3: w_enc = {6'b000001, in_ra, in_rb, in_rd, 5'd10, 6'd36};
      3'd4: w_enc = {6'b000001, in_ra, in_rb, in_rd, 5'd10, 6'd37};
      3'd5: w_enc = {6'b000001, in_ra, in_rb, in_rd, 5'd10, 6'd50};
      3'd6: w_enc = {6'b000010, in_ra, in_rd, in_imm};
      3'd7: w_enc = {6'b000011, in_ra, in_rb, in_imm};
      default: w_enc = NOP_W;
    endcase
  end

  assign w_empty  = (r_count == '0);
  assign in_ready = (r_count != (AW+1)'(DEPTH));
  assign w_push   = in_valid && in_ready;
  assign w_pop    = !w_empty && !w_stall;
  assign w_head   = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push && !rst) r_mem[r_wptr] <= w_enc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      instr_out   <= NOP_W;
      instr_real  <= 1'b0;
      issue_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_pop) begin
        instr_out   <= w_head;
        instr_real  <= 1'b1;
        issue_count <= issue_count + 16'd1;
      end else begin
        instr_out   <= NOP_W;
        instr_real  <= 1'b0;
      end
    end
  end

`ifdef INSTR_ISSUE_HAZARD_NOP_EN
  localparam int GW = $clog2(HAZARD_GAP + 1) + 1;

  logic [GW-1:0] r_gap_cnt;
  logic [4:0]    r_last_dst;
  logic          r_last_vld;

  logic [5:0] w_hop;
  logic [4:0] w_hrs;
  logic [4:0] w_hrt;
  logic       w_rd_rs;
  logic       w_rd_rt;
  logic [4:0] w_dst;
  logic       w_hit;

  assign w_hop = w_head[31:26];
  assign w_hrs = w_head[25:21];
  assign w_hrt = w_head[20:16];

  always_comb begin
    w_rd_rs = 1'b0;
    w_rd_rt = 1'b0;
    w_dst   = '0;
    unique case (1'b1)
      (w_hop == 6'b000001): begin
        w_rd_rs = 1'b1;
        w_rd_rt = 1'b1;
        w_dst   = w_head[15:11];
      end
      (w_hop == 6'b000010): begin
        w_rd_rs = 1'b1;
        w_dst   = w_head[20:16];
      end
      (w_hop == 6'b000011): begin
        w_rd_rs = 1'b1;
        w_rd_rt = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_hit = r_last_vld &&
                 ((w_rd_rs && w_hrs == r_last_dst) ||
                  (w_rd_rt && w_hrt == r_last_dst));
  assign w_stall = !w_empty && w_hit;

  // every filler after a real issue counts toward the gap, idle or stall
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gap_cnt  <= '0;
      r_last_dst <= '0;
      r_last_vld <= 1'b0;
    end else if (w_pop) begin
      r_gap_cnt  <= '0;
      r_last_dst <= w_dst;
      r_last_vld <= (w_dst != 5'd0) && (HAZARD_GAP > 0);
    end else if (r_last_vld) begin
      if (r_gap_cnt == GW'(HAZARD_GAP - 1)) begin
        r_gap_cnt  <= '0;
        r_last_vld <= 1'b0;
      end else begin
        r_gap_cnt  <= r_gap_cnt + 1'b1;
      end
    end
  end
`else
  // no hazard tracking: the gap setting has no effect
  assign w_stall = (HAZARD_GAP < 0);
`endif

endmodule
